// File: rtl/game_tick_gen.sv
// Tick generator: 1 Hz seconds pulse and level-dependent step pulse, both gated
// by a run/pause/idle FSM driven from edge-detected start/stop/speed_up inputs.
module game_tick_gen #(
  parameter int unsigned SEC_DIV   = 50_000_000,
  parameter int unsigned STEP_BASE = 25_000_000,
  parameter int unsigned STEP_DEC  = 2_500_000,
  parameter int unsigned MAX_LEVEL = 7
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       stop,
  input  logic       speed_up,
  output logic       sec_tick,
  output logic       step_tick,
  output logic [2:0] level,
  output logic       running
);

  localparam int unsigned SEC_W  = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;
  localparam int unsigned STEP_W = (STEP_BASE > 1) ? $clog2(STEP_BASE) : 1;
  localparam int unsigned LVL_W  = 3;

  localparam logic [SEC_W-1:0]  SEC_LAST     = SEC_W'(SEC_DIV - 1);
  localparam logic [STEP_W-1:0] STEP_BASE_M1 = STEP_W'(STEP_BASE - 1);
  localparam logic [STEP_W-1:0] STEP_DEC_W   = STEP_W'(STEP_DEC);
  localparam logic [LVL_W-1:0]  LVL_MAX      = LVL_W'(MAX_LEVEL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              start_dly_q, start_dly_d;
  logic              stop_dly_q, stop_dly_d;
  logic              speed_dly_q, speed_dly_d;
  logic [SEC_W-1:0]  sec_cnt_q, sec_cnt_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              sec_tick_q, sec_tick_d;
  logic              step_tick_q, step_tick_d;
  logic              running_q, running_d;

  logic              start_ev, stop_ev, speed_ev;
  logic              sec_wrap, step_wrap;
  logic [STEP_W-1:0] step_last;

  // Rising-edge events: holding an input high yields exactly one event.
  assign start_ev = start & ~start_dly_q;
  assign stop_ev  = stop & ~stop_dly_q;
  assign speed_ev = speed_up & ~speed_dly_q;

  // Last count value of the current step period, P(level) - 1.
  assign step_last = STEP_BASE_M1 - (STEP_W'(level_q) * STEP_DEC_W);
  assign sec_wrap  = (sec_cnt_q == SEC_LAST);
  assign step_wrap = (step_cnt_q >= step_last);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      start_dly_q <= 1'b0;
      stop_dly_q  <= 1'b0;
      speed_dly_q <= 1'b0;
      sec_cnt_q   <= '0;
      step_cnt_q  <= '0;
      level_q     <= '0;
      sec_tick_q  <= 1'b0;
      step_tick_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      start_dly_q <= start_dly_d;
      stop_dly_q  <= stop_dly_d;
      speed_dly_q <= speed_dly_d;
      sec_cnt_q   <= sec_cnt_d;
      step_cnt_q  <= step_cnt_d;
      level_q     <= level_d;
      sec_tick_q  <= sec_tick_d;
      step_tick_q <= step_tick_d;
      running_q   <= running_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    start_dly_d = start;
    stop_dly_d  = stop;
    speed_dly_d = speed_up;
    sec_cnt_d   = sec_cnt_q;
    step_cnt_d  = step_cnt_q;
    level_d     = level_q;
    sec_tick_d  = 1'b0;
    step_tick_d = 1'b0;
    running_d   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_ev && !stop_ev) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (stop_ev) state_d = ST_PAUSE;
        sec_cnt_d  = sec_wrap ? '0 : sec_cnt_q + SEC_W'(1);
        step_cnt_d = step_wrap ? '0 : step_cnt_q + STEP_W'(1);
      end
      ST_PAUSE: begin
        if (stop_ev) state_d = ST_IDLE;
        else if (start_ev) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_IDLE) && speed_ev && (level_q < LVL_MAX)) begin
      level_d = level_q + LVL_W'(1);
    end

    // Entering or sitting in IDLE clears everything, overriding a same-cycle speed_up.
    if (state_d == ST_IDLE) begin
      sec_cnt_d  = '0;
      step_cnt_d = '0;
      level_d    = '0;
    end

    // A wrap on the edge that leaves RUN still advances the count but emits no tick.
    if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
      sec_tick_d  = sec_wrap;
      step_tick_d = step_wrap;
    end

    running_d = (state_d == ST_RUN);
  end

  assign sec_tick  = sec_tick_q;
  assign step_tick = step_tick_q;
  assign level     = level_q;
  assign running   = running_q;

endmodule

// File: tb/tb_game_tick_gen.sv
// Directed bench for game_tick_gen with small parameters (10/8/1/3); expected
// tick positions are hand-computed per stimulus span.
module tb_game_tick_gen;

  logic       clk;
  logic       resetn;
  logic       start;
  logic       stop;
  logic       speed_up;
  logic       sec_tick;
  logic       step_tick;
  logic [2:0] level;
  logic       running;

  int checks;
  int failures;

  game_tick_gen #(
    .SEC_DIV  (10),
    .STEP_BASE(8),
    .STEP_DEC (1),
    .MAX_LEVEL(3)
  ) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .start    (start),
    .stop     (stop),
    .speed_up (speed_up),
    .sec_tick (sec_tick),
    .step_tick(step_tick),
    .level    (level),
    .running  (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pulse expected at span cycle i when i = f, f+p, f+2p, ...; f = 0 means never.
  function automatic logic exp_at(input int i, input int f, input int p);
    return (f > 0) && (i >= f) && (((i - f) % p) == 0);
  endfunction

  task automatic run_span(input string tag, input int n, input logic exp_run,
                          input int sf, input int sp, input int tf, input int tp,
                          input bit toggle_speed);
    for (int i = 1; i <= n; i++) begin
      if (toggle_speed) speed_up = ((i % 2) == 0);
      cyc(1);
      chk({tag, " running"}, 32'(running), 32'(exp_run));
      chk({tag, " sec_tick"}, 32'(sec_tick), 32'(exp_at(i, sf, sp)));
      chk({tag, " step_tick"}, 32'(step_tick), 32'(exp_at(i, tf, tp)));
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    speed_up = 1'b0;

    cyc(3);
    chk("reset running", 32'(running), 32'd0);
    chk("reset level", 32'(level), 32'd0);
    chk("reset sec_tick", 32'(sec_tick), 32'd0);
    chk("reset step_tick", 32'(step_tick), 32'd0);
    resetn = 1'b1;
    cyc(2);
    chk("idle running", 32'(running), 32'd0);

    // Start from IDLE: sec every 10, step every 8 at level 0.
    start = 1'b1;
    cyc(1);
    chk("start running", 32'(running), 32'd1);
    chk("start level", 32'(level), 32'd0);
    start = 1'b0;
    run_span("run0", 20, 1'b1, 10, 10, 8, 8, 1'b0);

    // speed_up held for 20 cycles: one event only, period 7 from the next compare.
    speed_up = 1'b1;
    run_span("hold", 20, 1'b1, 10, 10, 3, 7, 1'b0);
    speed_up = 1'b0;
    chk("hold level", 32'(level), 32'd1);

    // Four separate pulses saturate at level 3, then period 5.
    run_span("pulses", 8, 1'b1, 0, 1, 3, 5, 1'b1);
    speed_up = 1'b0;
    chk("sat level", 32'(level), 32'd3);
    run_span("lvl3", 12, 1'b1, 2, 10, 5, 5, 1'b0);

    // Pause after 4 RUN cycles; 6 more RUN cycles after resume complete the second.
    run_span("pre_pause", 3, 1'b1, 0, 1, 3, 5, 1'b0);
    stop = 1'b1;
    cyc(1);
    chk("pause running", 32'(running), 32'd0);
    chk("pause sec_tick", 32'(sec_tick), 32'd0);
    chk("pause level", 32'(level), 32'd3);
    stop = 1'b0;
    run_span("paused", 50, 1'b0, 0, 1, 0, 1, 1'b0);
    start = 1'b1;
    cyc(1);
    chk("resume running", 32'(running), 32'd1);
    chk("resume sec_tick", 32'(sec_tick), 32'd0);
    start = 1'b0;
    run_span("resumed", 10, 1'b1, 6, 10, 4, 5, 1'b0);

    // Stop twice -> IDLE; speed_up alongside the clearing stop loses.
    stop = 1'b1;
    cyc(1);
    chk("stop1 running", 32'(running), 32'd0);
    stop = 1'b0;
    cyc(1);
    stop     = 1'b1;
    speed_up = 1'b1;
    cyc(1);
    chk("stop2 running", 32'(running), 32'd0);
    chk("stop2 level", 32'(level), 32'd0);
    stop     = 1'b0;
    speed_up = 1'b0;
    cyc(1);
    speed_up = 1'b1;
    cyc(1);
    chk("idle speed level", 32'(level), 32'd0);
    speed_up = 1'b0;

    // Restart with cleared counters; step_cnt=6 at level 0, then a level-up lands mid-count.
    start = 1'b1;
    cyc(1);
    chk("restart running", 32'(running), 32'd1);
    chk("restart level", 32'(level), 32'd0);
    start = 1'b0;
    run_span("restart", 6, 1'b1, 0, 1, 0, 1, 1'b0);
    speed_up = 1'b1;
    run_span("midcount", 15, 1'b1, 4, 10, 2, 7, 1'b0);
    speed_up = 1'b0;
    chk("midcount level", 32'(level), 32'd1);

    // start and stop together in RUN: stop wins; wrap on the leaving edge gives no tick.
    start = 1'b1;
    stop  = 1'b1;
    cyc(1);
    chk("both running", 32'(running), 32'd0);
    chk("both step_tick", 32'(step_tick), 32'd0);
    chk("both sec_tick", 32'(sec_tick), 32'd0);
    start    = 1'b0;
    stop     = 1'b0;
    speed_up = 1'b1;
    cyc(1);
    chk("pause speed level", 32'(level), 32'd2);
    speed_up = 1'b0;
    start    = 1'b1;
    cyc(1);
    chk("resume2 running", 32'(running), 32'd1);
    start = 1'b0;
    run_span("lvl2", 3, 1'b1, 0, 1, 0, 1, 1'b0);

    // Asynchronous reset mid-count, between clock edges.
    #2;
    resetn = 1'b0;
    #1;
    chk("async running", 32'(running), 32'd0);
    chk("async level", 32'(level), 32'd0);
    chk("async sec_tick", 32'(sec_tick), 32'd0);
    chk("async step_tick", 32'(step_tick), 32'd0);
    cyc(2);
    resetn = 1'b1;
    cyc(5);
    chk("post reset running", 32'(running), 32'd0);
    chk("post reset level", 32'(level), 32'd0);
    start = 1'b1;
    cyc(1);
    chk("post reset start", 32'(running), 32'd1);
    start = 1'b0;
    run_span("fresh", 10, 1'b1, 10, 10, 8, 8, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
